// File: rtl/lb_uart_tx.sv
// lb_uart_tx: LB-bus responder with a small TX FIFO feeding an 8N1 UART transmitter.
module lb_uart_tx #(
    parameter int LB_ADDR_WIDTH = 16,
    parameter int BASE_ADDR = 0,
    parameter int FIFO_DEPTH = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic                     lb_clk,
    input  logic                     rst,
    input  logic                     ren,
    input  logic                     wen,
    input  logic [LB_ADDR_WIDTH-1:0] addr,
    input  logic [31:0]              wdata,
    input  logic [1:0]               write_width,
    output logic [31:0]              lb_data_out,
    output logic                     uart_tx,
    output logic                     irq
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [LB_ADDR_WIDTH-1:0] BASE = LB_ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wp, rp;
    logic [PW:0]   count;
    logic          overflow;
    logic [15:0]   div, baud;
    logic [7:0]    shreg;
    logic [2:0]    bit_idx;
    logic          hit, full, empty, push, pop, busy;
    logic [1:0]    off;
    logic [31:0]   rdata;
    logic          unused_bits;

    always_comb begin
        hit = addr[LB_ADDR_WIDTH-1:4] == BASE[LB_ADDR_WIDTH-1:4];
        off = addr[3:2];
        full = count == (PW+1)'(FIFO_DEPTH);
        empty = count == '0;
        busy = state != IDLE;
        push = wen && hit && off == 2'd0;
        pop = state == IDLE && !empty;
        rdata = off == 2'd1 ? {16'h0, 8'(count), 4'h0, overflow, empty, full, busy}
              : off == 2'd2 ? {16'h0, div} : 32'h0;
        lb_data_out = ren && hit ? rdata : 32'h0;
        unused_bits = ^{wdata[31:16], addr[1:0]};
    end

    always_ff @(posedge lb_clk) begin
        if (push && !full) mem[wp] <= wdata[7:0];
    end

    always_ff @(posedge lb_clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
            overflow <= 1'b0;
            div <= DEFAULT_DIV;
        end else begin
            if (push && !full) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count <= count + (PW+1)'(push && !full) - (PW+1)'(pop);
            if (push && full) overflow <= 1'b1;
            else if (wen && hit && off == 2'd1 && wdata[3]) overflow <= 1'b0;
            // byte-wide writes touch only the low byte; half and word widths load all 16 bits
            if (wen && hit && off == 2'd2) div <= write_width == 2'd0 ? {div[15:8], wdata[7:0]} : wdata[15:0];
        end
    end

    always_ff @(posedge lb_clk) begin
        if (rst) begin
            state <= IDLE;
            baud <= '0;
            shreg <= '0;
            bit_idx <= '0;
            uart_tx <= 1'b1;
            irq <= 1'b1;
        end else begin
            irq <= state == IDLE && empty;
            case (state)
                IDLE: if (!empty) begin
                    shreg <= mem[rp];
                    baud <= div;
                    uart_tx <= 1'b0;
                    state <= START;
                end
                START: if (baud == '0) begin
                    baud <= div;
                    uart_tx <= shreg[0];
                    shreg <= shreg >> 1;
                    bit_idx <= '0;
                    state <= DATA;
                end else baud <= baud - 1'b1;
                DATA: if (baud == '0) begin
                    baud <= div;
                    if (bit_idx == 3'd7) begin
                        uart_tx <= 1'b1;
                        state <= STOP;
                    end else begin
                        uart_tx <= shreg[0];
                        shreg <= shreg >> 1;
                        bit_idx <= bit_idx + 1'b1;
                    end
                end else baud <= baud - 1'b1;
                STOP: if (baud == '0) state <= IDLE;
                      else baud <= baud - 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lb_uart_tx.sv
// tb_lb_uart_tx: directed + randomized bench; a serial-line receiver model checks every frame bit-by-bit.
`timescale 1ns/1ps
module tb_lb_uart_tx;
    localparam logic [15:0] A_TX = 16'h0040, A_ST = 16'h0044, A_DIV = 16'h0048, A_DIV1 = 16'h0049;
    localparam logic [15:0] A_OFF3 = 16'h004C, A_MISS = 16'h0050, A_MISS_DIV = 16'h0058;

    logic        lb_clk = 1'b0, rst = 1'b1, ren = 1'b0, wen = 1'b0;
    logic [15:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [1:0]  write_width = '0;
    logic [31:0] lb_data_out;
    logic        uart_tx, irq;

    int         ncmp = 0, nerr = 0, mdiv = 433;
    logic [7:0] exp_q[$];
    bit         mon_busy = 1'b0;

    always #5 lb_clk = ~lb_clk;

    lb_uart_tx #(.LB_ADDR_WIDTH(16), .BASE_ADDR('h40), .FIFO_DEPTH(8), .DEFAULT_DIV(16'd433)) dut (
        .lb_clk(lb_clk), .rst(rst), .ren(ren), .wen(wen), .addr(addr), .wdata(wdata),
        .write_width(write_width), .lb_data_out(lb_data_out), .uart_tx(uart_tx), .irq(irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [1:0] ww);
        addr = a; wdata = d; write_width = ww; ren = 1'b0; wen = 1'b1;
        @(posedge lb_clk); #1;
        wen = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [15:0] a, input logic [31:0] exp);
        addr = a; wen = 1'b0; ren = 1'b1;
        #1 chk(tag, lb_data_out, exp);
        @(posedge lb_clk); #1;
        ren = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge lb_clk); #1; end
    endtask

    task automatic send(input logic [7:0] b);
        logic [31:0] r;
        r = $urandom;
        exp_q.push_back(b);
        wr(A_TX, {r[31:8], b}, r[1:0]);
    endtask

    task automatic set_div(input logic [15:0] d);
        logic [31:0] r;
        r = $urandom;
        wr(A_DIV, {r[31:16], d}, 2'd1);
        mdiv = int'(d);
    endtask

    task automatic wait_idle(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge lb_clk);
            if (exp_q.size() == 0 && !mon_busy && uart_tx === 1'b1 && irq === 1'b1) begin
                done = 1'b1;
                break;
            end
        end
        chk(tag, 32'(done), 32'd1);
        @(posedge lb_clk); #1;
    endtask

    function automatic logic [31:0] status_exp(input bit busy, input bit ovf, input int cnt);
        return {16'h0, 8'(cnt), 4'h0, ovf, cnt == 0, cnt == 8, busy};
    endfunction

    // Receiver model: each frame is 10 bit-times of mdiv+1 cycles, start 0, data LSB first, stop 1.
    initial begin
        logic [7:0] b;
        logic       e;
        bit         ab, want_start;
        int         len, k;
        want_start = 1'b0;
        forever begin
            @(negedge lb_clk);
            if (want_start && !rst) chk("gap_start", 32'(uart_tx), 32'd0);
            want_start = 1'b0;
            if (rst || uart_tx !== 1'b0) continue;
            mon_busy = 1'b1;
            chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
            b = 8'h00;
            if (exp_q.size() != 0) b = exp_q.pop_front();
            chk("irq_busy", 32'(irq), 32'd0);
            len = 10 * (mdiv + 1);
            ab = 1'b0;
            for (int t = 0; t < len; t++) begin
                if (t > 0) @(negedge lb_clk);
                k = t / (mdiv + 1);
                e = k == 0 ? 1'b0 : k == 9 ? 1'b1 : b[k-1];
                chk("tx_bit", 32'(uart_tx), 32'(e));
                if (rst) begin ab = 1'b1; break; end
            end
            if (!ab) begin
                if (exp_q.size() != 0) begin
                    @(negedge lb_clk);
                    chk("gap_idle", 32'(uart_tx), 32'd1);
                    want_start = 1'b1;
                end else begin
                    @(negedge lb_clk);
                    chk("irq_lag", 32'(irq), 32'd0);
                    @(negedge lb_clk);
                    chk("irq_rise", 32'(irq), 32'd1);
                end
            end
            mon_busy = 1'b0;
        end
    end

    initial begin
        bit         movf, quiet;
        logic [7:0] b;
        int         n;
        repeat (3) @(posedge lb_clk);
        #1 rst = 1'b0;
        chk("rst_tx", 32'(uart_tx), 32'd1);
        chk("rst_irq", 32'(irq), 32'd1);
        rd("rst_status", A_ST, 32'h4);
        #1 chk("rdata_idle", lb_data_out, 32'h0);
        rd("rst_div", A_DIV, 32'd433);

        wr(A_DIV, 32'h0000_3456, 2'd2);
        wr(A_DIV, 32'h0000_0012, 2'd0);
        rd("div_byte", A_DIV, 32'h0000_3412);
        wr(A_DIV, 32'hFFFF_0007, 2'd3);
        rd("div_ww3_lowbits", A_DIV1, 32'h7);
        wr(A_MISS_DIV, 32'h1234, 2'd1);
        rd("div_miss_wr", A_DIV, 32'h7);
        wr(A_OFF3, 32'h55, 2'd1);
        rd("div_off3_wr", A_DIV, 32'h7);
        rd("off3_rd", A_OFF3, 32'h0);
        rd("miss_rd", A_MISS_DIV, 32'h0);
        rd("txdata_rd", A_TX, 32'h0);
        wr(A_MISS, 32'h77, 2'd0);
        rd("miss_push", A_ST, 32'h4);

        set_div(16'd3);
        exp_q.push_back(8'hA5);
        wr(A_TX, 32'h0000_00A5, 2'd0);
        chk("tx_before_pop", 32'(uart_tx), 32'd1);
        rd("push_count", A_ST, status_exp(1'b0, 1'b0, 1));
        chk("tx_start_latency", 32'(uart_tx), 32'd0);
        rd("busy_status", A_ST, status_exp(1'b1, 1'b0, 0));
        wait_idle("drain_a5");
        rd("idle_status", A_ST, 32'h4);

        send(8'($urandom));
        send(8'($urandom));
        rd("pushpop_count", A_ST, status_exp(1'b1, 1'b0, 1));
        wait_idle("drain_pushpop");

        movf = 1'b0;
        send(8'($urandom));
        idle(4);
        for (int j = 0; j < 9; j++) begin
            b = 8'($urandom);
            if (exp_q.size() < 8) send(b);
            else begin
                movf = 1'b1;
                wr(A_TX, {24'h0, b}, 2'd2);
            end
        end
        rd("ovf_status", A_ST, status_exp(1'b1, movf, exp_q.size()));
        wr(A_ST, 32'hFFFF_FFF7, 2'd2);
        rd("ovf_sticky", A_ST, status_exp(1'b1, movf, exp_q.size()));
        wr(A_ST, 32'h8, 2'd2);
        rd("ovf_clear", A_ST, status_exp(1'b1, 1'b0, exp_q.size()));
        wait_idle("drain_ovf");

        for (int r = 0; r < 4; r++) begin
            set_div(16'($urandom_range(0, 5)));
            n = $urandom_range(1, 5);
            for (int j = 0; j < n; j++) send(8'($urandom));
            wait_idle("drain_rand");
            rd("rand_status", A_ST, 32'h4);
        end

        set_div(16'd3);
        for (int j = 0; j < 3; j++) send(8'($urandom));
        idle(10);
        rst = 1'b1;
        exp_q.delete();
        @(posedge lb_clk); #1;
        rst = 1'b0;
        mdiv = 433;
        chk("rst_mid_tx", 32'(uart_tx), 32'd1);
        chk("rst_mid_irq", 32'(irq), 32'd1);
        rd("rst_mid_status", A_ST, 32'h4);
        rd("rst_mid_div", A_DIV, 32'd433);
        quiet = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge lb_clk);
            if (uart_tx !== 1'b1) quiet = 1'b0;
        end
        chk("no_frame_after_rst", 32'(quiet), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
